midi_msg_ctrl: RTL and testbench

Sequencing controller for the MIDI receive datapath. Classifies each byte presented on `Din`/`Din_rdy` (from the UART byte receiver) and generates the `ld_status`/`ld_data1`/`ld_data2` strobes that load the datapath's status, D1 and D2 registers. Handles one- and two-data-byte channel messages, running status, real-time byte filtering, and timeout of incomplete messages. Pulses `msg_done` when the datapath holds a complete message.

---
 rtl/midi_msg_ctrl_pkg.sv | 29 ++
 rtl/midi_msg_ctrl_byte_class.sv | 26 ++
 rtl/midi_msg_ctrl.sv | 149 ++++++++++++++
 tb/tb_midi_msg_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/midi_msg_ctrl_pkg.sv
// Shared types and constants for the MIDI receive sequencing controller.
// Imported by midi_byte_class and midi_msg_ctrl.
package constantsMIDI;

  // Controller FSM states: waiting for status, first data byte, second data byte
  typedef enum logic [1:0] {
    IDLE,
    WAIT_D1,
    WAIT_D2
  } ctrl_state_t;

  // Classes of received bytes
  //   DATA : 0x00-0x7F
  //   CH2  : channel status followed by two data bytes (0x80-0xBF, 0xE0-0xEF)
  //   CH1  : channel status followed by one data byte  (0xC0-0xDF)
  //   SYS  : system common (0xF0-0xF7)
  //   RT   : real-time (0xF8-0xFF)
  typedef enum logic [2:0] {
    DATA,
    CH2,
    CH1,
    SYS,
    RT
  } midi_byte_t;

  localparam logic [7:0] SYS_COMMON_MIN = 8'hF0;
  localparam logic [7:0] REALTIME_MIN   = 8'hF8;

endpackage

// File: rtl/midi_msg_ctrl_byte_class.sv
// Purely combinational classifier mapping a received byte to its MIDI byte class.
module midi_byte_class
  import constantsMIDI::*;
(
  input  logic [7:0] din,
  output midi_byte_t byte_class
);

  // Decode the byte class from the top bits; real-time is tested before
  // system common because its range sits inside 0xF0-0xFF
  always_comb begin
    byte_class = DATA;
    if (din[7] == 1'b0) begin
      byte_class = DATA;
    end else if (din >= REALTIME_MIN) begin
      byte_class = RT;
    end else if (din >= SYS_COMMON_MIN) begin
      byte_class = SYS;
    end else if (din[6:5] == 2'b10) begin
      byte_class = CH1;
    end else begin
      byte_class = CH2;
    end
  end

endmodule

// File: rtl/midi_msg_ctrl.sv
// Sequencing controller for the MIDI receive datapath.
// Classifies each strobed byte and produces the load strobes for the status,
// D1 and D2 registers, a completion pulse and a timeout pulse for partial
// messages.
// Optional feature: define MIDI_RUNNING_STATUS_EN to accept data bytes in IDLE
// under the most recent channel status (running status). Without it every
// message needs its own status byte.
module midi_msg_ctrl
  import constantsMIDI::*;
#(
  parameter int TIMEOUT_CYCLES = 32000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] Din,
  input  logic       Din_rdy,
  output logic       ld_status,
  output logic       ld_data1,
  output logic       ld_data2,
  output logic       msg_done,
  output logic       msg_len2,
  output logic       err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  ctrl_state_t      state;
  ctrl_state_t      next_state;
  midi_byte_t       byte_class;
  logic             rs_valid;
  logic             rs_len2;
  logic [CNT_W-1:0] cnt;

  logic is_status;
  logic is_sys;
  logic is_data;
  logic byte_taken;
  logic d1_path;
  logic d2_path;
  logic expire;
  logic done_set;
  logic done_len2;

  midi_byte_class u_class (
    .din        (Din),
    .byte_class (byte_class)
  );

  // Qualify the decoded class with the strobe; real-time bytes never count
  // as taken so they cannot hold off a timeout
  always_comb begin
    is_status  = Din_rdy && ((byte_class == CH1) || (byte_class == CH2));
    is_sys     = Din_rdy && (byte_class == SYS);
    is_data    = Din_rdy && (byte_class == DATA);
    byte_taken = Din_rdy && (byte_class != RT);
    d1_path    = is_data && ((state == WAIT_D1) || ((state == IDLE) && rs_valid));
    d2_path    = is_data && (state == WAIT_D2);
    expire     = (state != IDLE) && (cnt == CNT_LAST) && !byte_taken;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: status restarts a message from anywhere, system common and
  // timeout abandon it, data advances it
  always_comb begin
    next_state = state;
    if (is_status) begin
      next_state = WAIT_D1;
    end else if (is_sys) begin
      next_state = IDLE;
    end else if (d1_path) begin
      next_state = rs_len2 ? WAIT_D2 : IDLE;
    end else if (d2_path) begin
      next_state = IDLE;
    end else if (expire) begin
      next_state = IDLE;
    end
  end

  // Output decode: load strobes are same-cycle so the datapath captures Din
  // on the edge that consumes it; classes are disjoint so one strobe at most
  always_comb begin
    ld_status = is_status;
    ld_data1  = d1_path;
    ld_data2  = d2_path;
    done_set  = (d1_path && !rs_len2) || d2_path;
    done_len2 = d2_path;
  end

  // Remember the last channel status length for WAIT_D1 decisions and for
  // running status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_len2 <= 1'b0;
    end else if (is_status) begin
      rs_len2 <= (byte_class == CH2);
    end
  end

`ifdef MIDI_RUNNING_STATUS_EN
  // Running status is armed by any channel status and cancelled by system
  // common; a timeout leaves it armed so the next data byte restarts a message
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_valid <= 1'b0;
    end else if (is_status) begin
      rs_valid <= 1'b1;
    end else if (is_sys) begin
      rs_valid <= 1'b0;
    end
  end
`else
  assign rs_valid = 1'b0;
`endif

  // Inter-byte idle counter: runs only while a message is open, restarts on
  // every accepted byte and rests at zero whenever the FSM heads to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ld_status || ld_data1 || ld_data2 || (next_state == IDLE)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Registered completion and timeout pulses, one cycle after the deciding edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_done    <= 1'b0;
      msg_len2    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      msg_done    <= done_set;
      msg_len2    <= done_set && done_len2;
      err_timeout <= expire;
    end
  end

endmodule

// File: tb/tb_midi_msg_ctrl.sv
// Self-checking bench for midi_msg_ctrl with TIMEOUT_CYCLES = 8.
// Expectations that depend on running status follow MIDI_RUNNING_STATUS_EN.
module tb_midi_msg_ctrl;

  localparam int TO = 8;
`ifdef MIDI_RUNNING_STATUS_EN
  localparam logic RS = 1'b1;
`else
  localparam logic RS = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] Din;
  logic       Din_rdy;
  logic       ld_status;
  logic       ld_data1;
  logic       ld_data2;
  logic       msg_done;
  logic       msg_len2;
  logic       err_timeout;

  int compared;
  int mismatched;

  // Expected outputs packed as {ld_status, ld_data1, ld_data2, msg_done, msg_len2, err_timeout}
  typedef struct {
    logic       rdy;
    logic [7:0] din;
    logic [5:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  midi_msg_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Din         (Din),
    .Din_rdy     (Din_rdy),
    .ld_status   (ld_status),
    .ld_data1    (ld_data1),
    .ld_data2    (ld_data2),
    .msg_done    (msg_done),
    .msg_len2    (msg_len2),
    .err_timeout (err_timeout)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {ld_status, ld_data1, ld_data2, msg_done, msg_len2, err_timeout};
  endfunction

  // Drive one cycle's inputs away from the rising edge, then let comb logic settle
  task automatic applyStimulus(input logic rdy, input logic [7:0] din);
    @(negedge clk);
    Din_rdy = rdy;
    Din     = din;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic addVec(input logic rdy, input logic [7:0] din, input logic [5:0] exp, input string name);
    vec_t v;
    v.rdy  = rdy;
    v.din  = din;
    v.exp  = exp;
    v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    int firstErr;
    int errCount;

    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    Din        = 8'h00;
    Din_rdy    = 1'b0;

    // Reset state and idle
    addVec(1'b0, 8'h00, 6'b000000, "reset_idle");
    // Note on, two data bytes, back to back
    addVec(1'b1, 8'h90, 6'b100000, "noteon_status");
    addVec(1'b1, 8'h3C, 6'b010000, "noteon_d1");
    addVec(1'b1, 8'h64, 6'b001000, "noteon_d2");
    addVec(1'b0, 8'h00, 6'b000110, "noteon_done");
    // Running status continuation
    addVec(1'b1, 8'h40, {1'b0, RS, 1'b0, 3'b000}, "rs_d1");
    addVec(1'b1, 8'h00, {2'b00, RS, 3'b000}, "rs_d2");
    addVec(1'b0, 8'h00, {3'b000, RS, RS, 1'b0}, "rs_done");
    // Program change with a real-time byte interleaved
    addVec(1'b1, 8'hC5, 6'b100000, "pc_status");
    addVec(1'b1, 8'hF8, 6'b000000, "pc_realtime");
    addVec(1'b1, 8'h07, 6'b010000, "pc_d1");
    addVec(1'b0, 8'h00, 6'b000100, "pc_done");
    // System common interrupts a note on
    addVec(1'b1, 8'h90, 6'b100000, "intr_status");
    addVec(1'b1, 8'h3C, 6'b010000, "intr_d1");
    addVec(1'b1, 8'hF2, 6'b000000, "intr_syscommon");
    addVec(1'b1, 8'h40, 6'b000000, "intr_orphan");
    addVec(1'b0, 8'h00, 6'b000000, "intr_nodone");
    // Pitch bend (0xE0 range is two-byte)
    addVec(1'b1, 8'hE3, 6'b100000, "pb_status");
    addVec(1'b1, 8'h01, 6'b010000, "pb_d1");
    addVec(1'b1, 8'h02, 6'b001000, "pb_d2");
    addVec(1'b0, 8'h00, 6'b000110, "pb_done");
    // Channel pressure (0xD0 is one-byte) with an idle gap
    addVec(1'b1, 8'hD0, 6'b100000, "cp_status");
    addVec(1'b0, 8'h00, 6'b000000, "cp_gap");
    addVec(1'b1, 8'h7F, 6'b010000, "cp_d1");
    addVec(1'b0, 8'h00, 6'b000100, "cp_done");
    // New status mid-message drops the partial one silently
    addVec(1'b1, 8'h90, 6'b100000, "drop_status");
    addVec(1'b1, 8'h11, 6'b010000, "drop_d1");
    addVec(1'b1, 8'hC0, 6'b100000, "drop_newstatus");
    addVec(1'b1, 8'h22, 6'b010000, "drop_pc_d1");
    addVec(1'b0, 8'h00, 6'b000100, "drop_done");

    // Outputs while held in reset
    #12;
    checkOutput("in_reset", {2'b00, outs()}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rdy, vecs[i].din);
      checkOutput(vecs[i].name, {2'b00, outs()}, {2'b00, vecs[i].exp});
    end

    // Timeout: status, then a data byte exactly in the expiry cycle, then idle
    applyStimulus(1'b1, 8'h80);
    checkOutput("to_status", {2'b00, outs()}, 8'b00100000);
    for (int i = 0; i < TO - 1; i++) begin
      applyStimulus(1'b0, 8'h00);
    end
    applyStimulus(1'b1, 8'h3C);
    checkOutput("to_race_d1", {2'b00, outs()}, 8'b00010000);
    firstErr = -1;
    errCount = 0;
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b0, 8'h00);
      if (err_timeout === 1'b1) begin
        errCount++;
        if (firstErr < 0) firstErr = k - 1;
      end
    end
    checkOutput("to_edges_after_byte", 8'(firstErr), 8'(TO));
    checkOutput("to_pulse_width", 8'(errCount), 8'd1);
    applyStimulus(1'b1, 8'h10);
    checkOutput("to_rs_restart", {2'b00, outs()}, {3'b000, RS, 4'b0000});

    // Reset mid-message discards it
    applyStimulus(1'b1, 8'hB0);
    checkOutput("rst_status", {2'b00, outs()}, 8'b00100000);
    applyStimulus(1'b1, 8'h07);
    checkOutput("rst_d1", {2'b00, outs()}, 8'b00010000);
    @(negedge clk);
    rst_n   = 1'b0;
    Din_rdy = 1'b0;
    Din     = 8'h00;
    #1;
    checkOutput("rst_asserted", {2'b00, outs()}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'h55);
    checkOutput("rst_after_data", {2'b00, outs()}, 8'h00);
    applyStimulus(1'b0, 8'h00);
    checkOutput("rst_no_done", {2'b00, outs()}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
